// File: rtl/twitch_tdm_scheduler_if.sv
// Operand/result handshake between the TDM scheduler and the shared twitch datapath.
// The scheduler is the master: it presents operands with dp_req and takes dp_y_i on dp_ack.
interface twitch_tdm_scheduler_if;
    logic        dp_req;
    logic [31:0] dp_x_i1;
    logic [31:0] dp_x_i2;
    logic [31:0] dp_y_i1;
    logic [31:0] dp_y_i2;
    logic [31:0] dp_tau;
    logic        dp_ack;
    logic [31:0] dp_y_i;

    modport master (
        output dp_req, dp_x_i1, dp_x_i2, dp_y_i1, dp_y_i2, dp_tau,
        input  dp_ack, dp_y_i
    );

    modport slave (
        input  dp_req, dp_x_i1, dp_x_i2, dp_y_i1, dp_y_i2, dp_tau,
        output dp_ack, dp_y_i
    );
endinterface

// File: rtl/twitch_tdm_scheduler.sv
// Walks N_CH motor-unit channels per sim_tick through one shared twitch datapath,
// keeping each channel's x/y history and tau locally; history update is pure register moves.
module twitch_tdm_scheduler #(
    parameter int unsigned N_CH    = 8,
    parameter int unsigned CH_W    = 3,
    parameter logic [31:0] TAU_RST = 32'h3D23D70A
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sim_tick,
    output logic [CH_W-1:0]       spike_addr,
    input  logic [31:0]           spike_fp,
    input  logic                  cfg_we,
    input  logic [CH_W-1:0]       cfg_addr,
    input  logic [31:0]           cfg_tau,
    twitch_tdm_scheduler_if.master dp,
    output logic                  force_valid,
    output logic [CH_W-1:0]       force_ch,
    output logic [31:0]           force_out,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun
);
    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WB, DONE} state_t;

    state_t          state, state_next;
    logic [CH_W-1:0] ch;
    logic [31:0]     x_i1 [N_CH];
    logic [31:0]     x_i2 [N_CH];
    logic [31:0]     y_i1 [N_CH];
    logic [31:0]     y_i2 [N_CH];
    logic [31:0]     tau  [N_CH];
    logic [31:0]     tau_cur;
    logic [31:0]     spike_cap;
    logic [31:0]     y_res;
    logic            first;
    logic            last_ch;
    logic            start;
    logic            cfg_ok;

    assign last_ch = (ch == CH_W'(N_CH - 1));
    // A tick landing on the frame_done cycle is treated as an overrun, not a new frame.
    assign start   = sim_tick && !frame_done;

    generate
        if (N_CH == (1 << CH_W)) begin : g_cfg_full
            assign cfg_ok = 1'b1;
        end else begin : g_cfg_range
            assign cfg_ok = (32'(cfg_addr) < N_CH);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = FETCH;
            FETCH:   state_next = ISSUE;
            ISSUE:   if (dp.dp_ack) state_next = WB;
            WB:      state_next = last_ch ? DONE : FETCH;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign spike_addr = ch;
    assign dp.dp_req  = (state == ISSUE);
    assign dp.dp_x_i1 = dp.dp_req ? x_i1[ch] : '0;
    assign dp.dp_x_i2 = dp.dp_req ? x_i2[ch] : '0;
    assign dp.dp_y_i1 = dp.dp_req ? y_i1[ch] : '0;
    assign dp.dp_y_i2 = dp.dp_req ? y_i2[ch] : '0;
    assign dp.dp_tau  = tau_cur;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ch          <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
            force_valid <= 1'b0;
            force_ch    <= '0;
            force_out   <= '0;
            tau_cur     <= '0;
            spike_cap   <= '0;
            y_res       <= '0;
            first       <= 1'b0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                x_i1[i] <= '0;
                x_i2[i] <= '0;
                y_i1[i] <= '0;
                y_i2[i] <= '0;
                tau[i]  <= TAU_RST;
            end
        end else begin
            force_valid <= 1'b0;
            frame_done  <= 1'b0;
            if (sim_tick && (busy || frame_done)) overrun <= 1'b1;
            if (cfg_we && cfg_ok) tau[cfg_addr] <= cfg_tau;
            case (state)
                IDLE: begin
                    if (start) begin
                        ch   <= '0;
                        busy <= 1'b1;
                    end
                end
                FETCH: begin
                    tau_cur <= tau[ch];
                    first   <= 1'b1;
                end
                ISSUE: begin
                    // spike_fp answers the FETCH-cycle address only on the first ISSUE cycle.
                    first <= 1'b0;
                    if (first)     spike_cap <= spike_fp;
                    if (dp.dp_ack) y_res     <= dp.dp_y_i;
                end
                WB: begin
                    x_i2[ch]    <= x_i1[ch];
                    x_i1[ch]    <= spike_cap;
                    y_i2[ch]    <= y_i1[ch];
                    y_i1[ch]    <= y_res;
                    force_out   <= y_res;
                    force_ch    <= ch;
                    force_valid <= 1'b1;
                    if (!last_ch) ch <= ch + CH_W'(1);
                end
                DONE: begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
